// File: rtl/ysyx_22040750_axi_pkg.sv
// Shared AXI constants and the read-arbiter FSM encoding for the ysyx_22040750 memory path.
package ysyx_22040750_axi_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_8B = 3'b011;

  // One-hot so each state bit can be probed directly by a checker.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_M0_AR = 5'b00010,
    ST_M0_R  = 5'b00100,
    ST_M1_AR = 5'b01000,
    ST_M1_R  = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/ysyx_22040750_axi_arbiter.sv
// Read-channel arbiter between icache (M0) and dcache (M1); M1 write channel passes straight through.
// Define YSYX_22040750_ARB_RR_EN for round-robin grant instead of fixed M1 > M0 priority.
module ysyx_22040750_axi_arbiter
  import ysyx_22040750_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  // M0 read
  input  logic [ADDR_W-1:0]     I_m0_araddr,
  input  logic                  I_m0_arvalid,
  input  logic [AXI_LEN_W-1:0]  I_m0_arlen,
  input  logic [AXI_SIZE_W-1:0] I_m0_arsize,
  output logic                  O_m0_arready,
  output logic [DATA_W-1:0]     O_m0_rdata,
  output logic                  O_m0_rvalid,
  output logic                  O_m0_rlast,
  input  logic                  I_m0_rready,
  // M1 read
  input  logic [ADDR_W-1:0]     I_m1_araddr,
  input  logic                  I_m1_arvalid,
  input  logic [AXI_LEN_W-1:0]  I_m1_arlen,
  input  logic [AXI_SIZE_W-1:0] I_m1_arsize,
  output logic                  O_m1_arready,
  output logic [DATA_W-1:0]     O_m1_rdata,
  output logic                  O_m1_rvalid,
  output logic                  O_m1_rlast,
  input  logic                  I_m1_rready,
  // M1 write
  input  logic [ADDR_W-1:0]     I_m1_awaddr,
  input  logic [AXI_LEN_W-1:0]  I_m1_awlen,
  input  logic [AXI_SIZE_W-1:0] I_m1_awsize,
  input  logic                  I_m1_awvalid,
  output logic                  O_m1_awready,
  input  logic [DATA_W-1:0]     I_m1_wdata,
  input  logic [DATA_W/8-1:0]   I_m1_wstrb,
  input  logic                  I_m1_wlast,
  input  logic                  I_m1_wvalid,
  output logic                  O_m1_wready,
  output logic                  O_m1_bvalid,
  input  logic                  I_m1_bready,
  // slave read
  output logic [ADDR_W-1:0]     O_s_araddr,
  output logic [AXI_LEN_W-1:0]  O_s_arlen,
  output logic [AXI_SIZE_W-1:0] O_s_arsize,
  output logic                  O_s_arvalid,
  input  logic                  I_s_arready,
  input  logic [DATA_W-1:0]     I_s_rdata,
  input  logic                  I_s_rvalid,
  input  logic                  I_s_rlast,
  output logic                  O_s_rready,
  // slave write
  output logic [ADDR_W-1:0]     O_s_awaddr,
  output logic [AXI_LEN_W-1:0]  O_s_awlen,
  output logic [AXI_SIZE_W-1:0] O_s_awsize,
  output logic                  O_s_awvalid,
  input  logic                  I_s_awready,
  output logic [DATA_W-1:0]     O_s_wdata,
  output logic [DATA_W/8-1:0]   O_s_wstrb,
  output logic                  O_s_wlast,
  output logic                  O_s_wvalid,
  input  logic                  I_s_wready,
  input  logic                  I_s_bvalid,
  output logic                  O_s_bready,
  // debug
  output logic [4:0]            O_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a source holds
  // valid and its payload stable until that edge, and never drops valid before it.

  arb_state_e state_q, state_d;
  logic       pick_m1;

`ifdef YSYX_22040750_ARB_RR_EN
  logic last_grant_q;  // 0 = M0 was granted last, 1 = M1
  logic ar_hs;

  assign ar_hs   = I_s_arready && (((state_q == ST_M0_AR) && I_m0_arvalid) ||
                                   ((state_q == ST_M1_AR) && I_m1_arvalid));
  assign pick_m1 = I_m1_arvalid && (!I_m0_arvalid || !last_grant_q);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      last_grant_q <= 1'b0;
    end else if (ar_hs) begin
      last_grant_q <= (state_q == ST_M1_AR);
    end
  end
`else
  assign pick_m1 = I_m1_arvalid;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    O_s_araddr   = '0;
    O_s_arlen    = '0;
    O_s_arsize   = '0;
    O_s_arvalid  = 1'b0;
    O_s_rready   = 1'b0;
    O_m0_arready = 1'b0;
    O_m0_rdata   = '0;
    O_m0_rvalid  = 1'b0;
    O_m0_rlast   = 1'b0;
    O_m1_arready = 1'b0;
    O_m1_rdata   = '0;
    O_m1_rvalid  = 1'b0;
    O_m1_rlast   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Grant is registered: the chosen master's AR reaches the slave next cycle.
        if (I_m0_arvalid || I_m1_arvalid) begin
          state_d = pick_m1 ? ST_M1_AR : ST_M0_AR;
        end
      end
      ST_M0_AR: begin
        O_s_araddr   = I_m0_araddr;
        O_s_arlen    = I_m0_arlen;
        O_s_arsize   = I_m0_arsize;
        O_s_arvalid  = I_m0_arvalid;
        O_m0_arready = I_s_arready;
        if (I_m0_arvalid && I_s_arready) begin
          state_d = ST_M0_R;
        end
      end
      ST_M0_R: begin
        O_m0_rdata  = I_s_rdata;
        O_m0_rvalid = I_s_rvalid;
        O_m0_rlast  = I_s_rlast;
        O_s_rready  = I_m0_rready;
        if (I_s_rvalid && I_m0_rready && I_s_rlast) begin
          state_d = ST_IDLE;
        end
      end
      ST_M1_AR: begin
        O_s_araddr   = I_m1_araddr;
        O_s_arlen    = I_m1_arlen;
        O_s_arsize   = I_m1_arsize;
        O_s_arvalid  = I_m1_arvalid;
        O_m1_arready = I_s_arready;
        if (I_m1_arvalid && I_s_arready) begin
          state_d = ST_M1_R;
        end
      end
      ST_M1_R: begin
        O_m1_rdata  = I_s_rdata;
        O_m1_rvalid = I_s_rvalid;
        O_m1_rlast  = I_s_rlast;
        O_s_rready  = I_m1_rready;
        if (I_s_rvalid && I_m1_rready && I_s_rlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign O_dbg_state = state_q;

  // Write channel belongs to M1 alone and runs alongside any read state.
  assign O_s_awaddr   = I_m1_awaddr;
  assign O_s_awlen    = I_m1_awlen;
  assign O_s_awsize   = I_m1_awsize;
  assign O_s_awvalid  = I_m1_awvalid;
  assign O_m1_awready = I_s_awready;
  assign O_s_wdata    = I_m1_wdata;
  assign O_s_wstrb    = I_m1_wstrb;
  assign O_s_wlast    = I_m1_wlast;
  assign O_s_wvalid   = I_m1_wvalid;
  assign O_m1_wready  = I_s_wready;
  assign O_m1_bvalid  = I_s_bvalid;
  assign O_s_bready   = I_m1_bready;

  // A granted master must keep arvalid up until its AR handshake.
  a_m0_ar_hold: assert property (@(posedge I_clk) disable iff (I_rst)
                                 (state_q == ST_M0_AR) |-> I_m0_arvalid);
  a_m1_ar_hold: assert property (@(posedge I_clk) disable iff (I_rst)
                                 (state_q == ST_M1_AR) |-> I_m1_arvalid);

endmodule
